dmem_request_ctrl: RTL and testbench
====================================

Name: dmem_request_ctrl

Overview:
- EX/MEM-stage data-memory request controller; consumes the hazard unit's mem_op and stall_exmem outputs and the EX/MEM latch fields; drives the datapath-to-cache request (dmemREN/dmemWEN).
- Issues exactly one cache request per memory instruction, latches load data on dhit, holds it until the pipeline advances, and asserts mem_stall to freeze upstream latches.
- Sequences halt and counts memory stall cycles for performance reporting.

Parameters:
- ADDR_W, 32, width of data address and store/load data (word_t).
- CNT_W, 32, width of the stall-cycle performance counter; saturates at all-ones.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- mem_op  in  1  hazard unit: EX/MEM holds a load or store.
- MemtoReg_exmem  in  1  EX/MEM instruction is a load.
- MemWr_exmem  in  1  EX/MEM instruction is a store.
- addr_exmem  in  ADDR_W  effective address from EX/MEM.
- store_exmem  in  ADDR_W  store data from EX/MEM.
- flush_exmem  in  1  hazard unit: squash EX/MEM contents.
- stall_exmem  in  1  hazard unit: hold EX/MEM (asserted on halt).
- halt_exmem  in  1  EX/MEM holds HALT.
- advance  in  1  pipeline latches update this cycle (ihit and no global stall).
- dhit  in  1  cache completed the current request.
- dmemload  in  ADDR_W  read data from cache, valid with dhit.
- dmemREN  out  1  read request.
- dmemWEN  out  1  write request.
- dmemaddr  out  ADDR_W  request address.
- dmemstore  out  ADDR_W  request store data.
- load_data  out  ADDR_W  latched load result for the MEM/WB latch.
- mem_stall  out  1  request outstanding; freeze IF..EX/MEM.
- halt_out  out  1  sticky halt to the cache/system.
- stall_cycles  out  CNT_W  cycles with mem_stall=1 since reset.

Behaviour:
- Reset (async, nRST=0): state=IDLE; dmemREN=dmemWEN=0; dmemaddr=dmemstore=load_data=0; mem_stall=0; halt_out=0; stall_cycles=0.
- States: IDLE, REQ, DONE, HALT.
- IDLE:
  - halt_exmem -> HALT.
  - Else mem_op and not flush_exmem -> REQ, issuing combinationally in the same cycle.
  - dmemREN=MemtoReg_exmem and dmemWEN=MemWr_exmem, gated by state=IDLE|REQ and mem_op.
  - If both MemtoReg_exmem and MemWr_exmem are 1, the read wins: dmemWEN=0.
- REQ:
  - dmemaddr/dmemstore driven from addr_exmem/store_exmem; mem_stall=1 while no dhit.
  - dhit with advance -> IDLE; load_data <= dmemload if load.
  - dhit without advance -> DONE; load_data captured.
  - flush_exmem without dhit -> IDLE; request dropped.
- DONE:
  - dmemREN=dmemWEN=0, so no re-issue; mem_stall=0.
  - load_data held; advance -> IDLE.
  - flush_exmem -> IDLE.
- HALT:
  - halt_out=1; no requests; mem_stall=0; exit only by reset.
  - halt_exmem takes priority over mem_op in the same cycle.
- Latency: minimum 1 cycle, request and dhit in the same cycle; load_data valid the cycle after dhit.
- Data path: dmemaddr and dmemstore are combinational from EX/MEM while a request is active, 0 otherwise.
- stall_cycles: +1 each cycle mem_stall=1; saturates at 2^CNT_W-1 with no wrap.
- dhit while in IDLE/DONE/HALT (spurious): ignored, no state change, load_data unchanged.
- stall_exmem: does not cancel an outstanding request; the FSM still waits for dhit.
- Reset mid-REQ: the outstanding request is abandoned immediately; the cache side tolerates request deassertion.

Decomposition:
- cpu_types_pkg: add a dmem_state_t enum (IDLE, REQ, DONE, HALT); word_t is reused.
- Interface: a dmem_request_ctrl_if.vh interface matching the existing *_if.vh style.
- Sub-module: sat_counter (parameterised CNT_W saturating counter) for stall_cycles.

Test Plan:
- Load, single-cycle hit: mem_op=1, MemtoReg=1, addr=0x100, dhit=1 same cycle with dmemload=0xDEADBEEF, advance=1 -> dmemREN=1 for 1 cycle; load_data=0xDEADBEEF next cycle; state IDLE; stall_cycles=0.
- Store, 3-cycle miss: MemWr=1, addr=0x40, store=0x1234, dhit on 3rd cycle -> dmemWEN=1 for 3 cycles; mem_stall=1 for 2 cycles; stall_cycles=2.
- dhit without advance: dhit cycle 2, advance cycle 5 -> REQ->DONE; dmemREN=0 in cycles 3-5 (no re-issue); load_data stable; IDLE after cycle 5.
- Flush mid-request: REQ for 2 cycles, then flush_exmem=1 with dhit=0 -> requests drop next cycle; state IDLE; load_data unchanged.
- Halt: halt_exmem=1 and mem_op=1 in the same cycle -> no request; halt_out=1 permanently; later mem_op/dhit ignored; nRST=0 clears all outputs asynchronously.
- Saturation: CNT_W=4, hold REQ for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/dmem_request_ctrl_pkg.sv
// Shared types for the EX/MEM data-memory request controller.
package dmem_request_ctrl_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    HALT
  } dmem_state_t;

endpackage

// File: rtl/dmem_request_ctrl_if.sv
// EX/MEM-to-cache request bundle; master is the controller, slave is pipeline/cache.
interface dmem_request_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              mem_op;
  logic              MemtoReg_exmem;
  logic              MemWr_exmem;
  logic [ADDR_W-1:0] addr_exmem;
  logic [ADDR_W-1:0] store_exmem;
  logic              flush_exmem;
  logic              stall_exmem;
  logic              halt_exmem;
  logic              advance;
  logic              dhit;
  logic [ADDR_W-1:0] dmemload;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [ADDR_W-1:0] dmemstore;
  logic [ADDR_W-1:0] load_data;
  logic              mem_stall;
  logic              halt_out;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    input  mem_op, MemtoReg_exmem, MemWr_exmem, addr_exmem, store_exmem,
           flush_exmem, stall_exmem, halt_exmem, advance, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, load_data, mem_stall,
           halt_out, stall_cycles
  );

  modport slave (
    output mem_op, MemtoReg_exmem, MemWr_exmem, addr_exmem, store_exmem,
           flush_exmem, stall_exmem, halt_exmem, advance, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, load_data, mem_stall,
           halt_out, stall_cycles
  );
endinterface

// File: rtl/dmem_request_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module dmem_request_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/dmem_request_ctrl.sv
// EX/MEM data-memory request controller: one cache request per memory op,
// load-data capture on dhit, upstream stall, sticky halt and stall counting.
module dmem_request_ctrl
  import dmem_request_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  dmem_request_ctrl_if.master bus
);
  dmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] load_q, load_d;
  logic              issue;
  logic              busy;

  // A new request needs a clean IDLE slot; once in REQ it is held until dhit or flush.
  always_comb begin
    issue = 1'b0;
    if (nRST) begin
      case (state_q)
        IDLE:    issue = bus.mem_op && !bus.halt_exmem && !bus.flush_exmem;
        REQ:     issue = bus.mem_op;
        default: issue = 1'b0;
      endcase
    end
  end

  assign busy          = nRST && ((state_q == REQ) || issue);
  assign bus.dmemREN   = issue && bus.MemtoReg_exmem;
  assign bus.dmemWEN   = issue && bus.MemWr_exmem && !bus.MemtoReg_exmem;
  assign bus.dmemaddr  = issue ? bus.addr_exmem  : '0;
  assign bus.dmemstore = issue ? bus.store_exmem : '0;
  assign bus.mem_stall = busy && !bus.dhit;
  assign bus.halt_out  = (state_q == HALT);
  assign bus.load_data = load_q;

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (bus.halt_exmem) begin
          state_d = HALT;
        end else if (issue) begin
          if (bus.dhit) begin
            if (bus.dmemREN) load_d = bus.dmemload;
            state_d = bus.advance ? IDLE : DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.dhit) begin
          if (bus.dmemREN) load_d = bus.dmemload;
          state_d = bus.advance ? IDLE : DONE;
        end else if (bus.flush_exmem) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (bus.advance || bus.flush_exmem) state_d = IDLE;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  dmem_request_ctrl_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk    (CLK),
    .rst_n  (nRST),
    .inc_i  (bus.mem_stall),
    .count_o(bus.stall_cycles)
  );
endmodule

// File: tb/tb_dmem_request_ctrl.sv
// Directed bench for dmem_request_ctrl with a transaction-level reference model.
module tb_dmem_request_ctrl;
  localparam int unsigned AW   = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  dmem_request_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  dmem_request_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request is either absent, in flight, parked awaiting advance, or the unit is halted.
  logic          m_halted, m_inflight, m_parked;
  logic [AW-1:0] m_load;
  int unsigned   m_cnt;

  always @(negedge CLK) begin
    logic req, busy, stall_e;
    if (!nRST) begin
      m_halted = 0; m_inflight = 0; m_parked = 0; m_load = '0; m_cnt = 0;
      check("rst_ren",   bus.dmemREN,      0);
      check("rst_wen",   bus.dmemWEN,      0);
      check("rst_addr",  bus.dmemaddr,     0);
      check("rst_store", bus.dmemstore,    0);
      check("rst_load",  bus.load_data,    0);
      check("rst_stall", bus.mem_stall,    0);
      check("rst_halt",  bus.halt_out,     0);
      check("rst_cnt",   bus.stall_cycles, 0);
    end else begin
      req  = !m_halted && !m_parked && bus.mem_op &&
             (m_inflight || (!bus.halt_exmem && !bus.flush_exmem));
      busy = !m_halted && !m_parked && (m_inflight || req);
      stall_e = busy && !bus.dhit;
      check("ren",   bus.dmemREN,   req && bus.MemtoReg_exmem);
      check("wen",   bus.dmemWEN,   req && bus.MemWr_exmem && !bus.MemtoReg_exmem);
      check("addr",  bus.dmemaddr,  req ? bus.addr_exmem : '0);
      check("store", bus.dmemstore, req ? bus.store_exmem : '0);
      check("stall", bus.mem_stall, stall_e);
      check("halt",  bus.halt_out,  m_halted);
      check("load",  bus.load_data, m_load);
      check("cnt",   bus.stall_cycles, m_cnt);
      if (m_halted) begin
      end else if (m_parked) begin
        if (bus.advance || bus.flush_exmem) m_parked = 0;
      end else if (busy) begin
        if (bus.dhit) begin
          if (req && bus.MemtoReg_exmem) m_load = bus.dmemload;
          m_inflight = 0;
          m_parked   = !bus.advance;
        end else if (m_inflight && bus.flush_exmem) begin
          m_inflight = 0;
        end else begin
          m_inflight = 1;
        end
      end else if (bus.halt_exmem) begin
        m_halted = 1;
      end
      if (stall_e && m_cnt != CMAX) m_cnt++;
    end
  end

  task automatic quiet();
    bus.mem_op = 0; bus.MemtoReg_exmem = 0; bus.MemWr_exmem = 0;
    bus.addr_exmem = '0; bus.store_exmem = '0; bus.flush_exmem = 0;
    bus.stall_exmem = 0; bus.halt_exmem = 0; bus.advance = 0;
    bus.dhit = 0; bus.dmemload = '0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 0;
    quiet();
    repeat (2) cyc();
    nRST = 1;
    cyc();
    check("lit_reset_cnt",  bus.stall_cycles, 0);
    check("lit_reset_load", bus.load_data, 0);

    // Load with same-cycle hit
    bus.mem_op = 1; bus.MemtoReg_exmem = 1; bus.addr_exmem = 32'h100;
    bus.dhit = 1; bus.dmemload = 32'hDEADBEEF; bus.advance = 1;
    #1;
    check("lit_hit_ren",  bus.dmemREN, 1);
    check("lit_hit_addr", bus.dmemaddr, 32'h100);
    check("lit_hit_stall", bus.mem_stall, 0);
    cyc();
    quiet();
    #1;
    check("lit_hit_load", bus.load_data, 32'hDEADBEEF);
    check("lit_hit_ren_off", bus.dmemREN, 0);
    check("lit_hit_cnt", bus.stall_cycles, 0);
    cyc();

    // Store, 3-cycle miss
    bus.mem_op = 1; bus.MemWr_exmem = 1; bus.addr_exmem = 32'h40; bus.store_exmem = 32'h1234;
    #1;
    check("lit_st_wen", bus.dmemWEN, 1);
    check("lit_st_data", bus.dmemstore, 32'h1234);
    cyc(); cyc();
    bus.dhit = 1; bus.advance = 1;
    cyc();
    quiet();
    #1;
    check("lit_st_cnt", bus.stall_cycles, 2);
    check("lit_st_load", bus.load_data, 32'hDEADBEEF);
    cyc();

    // dhit without advance: parked until advance
    bus.mem_op = 1; bus.MemtoReg_exmem = 1; bus.addr_exmem = 32'h80; bus.stall_exmem = 1;
    cyc();
    bus.dhit = 1; bus.dmemload = 32'hCAFE0001;
    cyc();
    bus.dhit = 0; bus.dmemload = 32'h0BAD0BAD;
    #1;
    check("lit_park_ren", bus.dmemREN, 0);
    check("lit_park_load", bus.load_data, 32'hCAFE0001);
    cyc(); cyc();
    bus.advance = 1; bus.stall_exmem = 0;
    cyc();
    quiet();
    cyc();

    // Flush mid-request
    bus.mem_op = 1; bus.MemtoReg_exmem = 1; bus.addr_exmem = 32'h200;
    cyc(); cyc();
    bus.flush_exmem = 1;
    cyc();
    quiet();
    #1;
    check("lit_fl_ren", bus.dmemREN, 0);
    check("lit_fl_load", bus.load_data, 32'hCAFE0001);
    check("lit_fl_cnt", bus.stall_cycles, 6);
    cyc();

    // Load and store both set: read wins
    bus.mem_op = 1; bus.MemtoReg_exmem = 1; bus.MemWr_exmem = 1; bus.addr_exmem = 32'h300;
    bus.store_exmem = 32'h77; bus.dhit = 1; bus.advance = 1; bus.dmemload = 32'h5555AAAA;
    #1;
    check("lit_rw_wen", bus.dmemWEN, 0);
    cyc();
    quiet();
    // Spurious dhit in IDLE
    bus.dhit = 1; bus.dmemload = 32'h11111111;
    cyc();
    quiet();
    #1;
    check("lit_spur_load", bus.load_data, 32'h5555AAAA);
    cyc();

    // Counter saturation
    bus.mem_op = 1; bus.MemtoReg_exmem = 1; bus.addr_exmem = 32'h400;
    repeat (20) cyc();
    check("lit_sat_cnt", bus.stall_cycles, CMAX);
    bus.dhit = 1; bus.advance = 1; bus.dmemload = 32'h0000F00D;
    cyc();
    quiet();
    cyc();

    // Halt beats mem_op; exits only through reset
    bus.halt_exmem = 1; bus.mem_op = 1; bus.MemtoReg_exmem = 1; bus.addr_exmem = 32'h500;
    #1;
    check("lit_halt_ren", bus.dmemREN, 0);
    cyc();
    bus.halt_exmem = 0;
    #1;
    check("lit_halt_out", bus.halt_out, 1);
    bus.dhit = 1; bus.advance = 1; bus.dmemload = 32'h99999999;
    repeat (3) cyc();
    check("lit_halt_sticky", bus.halt_out, 1);
    check("lit_halt_load", bus.load_data, 32'h0000F00D);
    nRST = 0;
    #1;
    check("lit_arst_halt", bus.halt_out, 0);
    check("lit_arst_cnt", bus.stall_cycles, 0);
    check("lit_arst_ren", bus.dmemREN, 0);
    check("lit_arst_load", bus.load_data, 0);
    cyc();
    quiet();
    nRST = 1;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
